clmul_seq: RTL and testbench
============================

Name: clmul_seq

Overview:
- Parametrised, sequential successor to the 2-bit combinational arithmetic slice.
- Two results per transaction, operands WIDTH bits each:
  - u: the carry-less (GF(2) polynomial) product x*y.
  - w: the integer increment y+z.
- The product is computed by iterative shift-and-XOR, one multiplier bit per cycle, behind valid/ready handshakes.
- Used as the arithmetic engine feeding the multi-bit matching datapath.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- EARLY_EXIT, 0, when 1 the multiply terminates as soon as the remaining (unprocessed) y bits are all zero.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, active-low.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- op  input  1  0 = multiply and increment; 1 = increment only (multiply bypassed).
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier, and addend for w.
- z  input  1  increment / carry-in for w.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- u  output  WIDTH  product bits [WIDTH-1:0].
- u_hi  output  WIDTH-1  product bits [2*WIDTH-2:WIDTH].
- w  output  WIDTH  (y+z) mod 2^WIDTH.
- w_cout  output  1  carry out of y+z.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - State = IDLE.
  - in_ready=1, out_valid=0.
  - u, u_hi, w, w_cout = 0.
  - Internal accumulator and bit counter = 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept condition: in_valid & in_ready, in IDLE. On accept:
  - Register x, y, op.
  - Compute {w_cout, w} = y + z and register it immediately. w and w_cout keep this value until the next accept.
  - Clear the (2*WIDTH-1)-bit accumulator and set the bit index i = 0.
- op=1: go directly to DONE. out_valid is asserted the cycle after accept; u = 0 and u_hi = 0.
- op=0: go to RUN. Each RUN cycle:
  - If y[i]=1, acc ^= (x << i).
  - Then i = i + 1.
  - After the cycle that processes i = WIDTH-1, go to DONE.
  - Latency: accept at cycle T gives out_valid at T+WIDTH.
- EARLY_EXIT=1: if the bits of y above the bit just processed are all zero, go to DONE after that cycle.
  - Result is identical to the full run.
  - Minimum latency 1 cycle (e.g. y=0 or y=1).
- DONE:
  - {u_hi, u} = acc, held stable while out_valid=1 and out_ready=0. Outputs must not change under backpressure.
  - On out_valid & out_ready, go to IDLE and drop out_valid the next cycle. in_ready rises the same cycle.
  - No accept in the handshake cycle itself: at most one transaction in flight.
- All arithmetic is modulo 2 (XOR) with no carries, except the w adder.
  - x<<i is zero-extended to 2*WIDTH-1 bits.
  - Maximum product degree is 2*WIDTH-2, so there is no overflow.
- Changes on x, y, z, op while not in IDLE are ignored.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values. The partial product is discarded and no out_valid pulse occurs.
- in_valid held high across transactions: the next accept happens in the first IDLE cycle.

Test Plan:
- Reset and idle:
  - Assert rst_n=0 mid-run with WIDTH=8, op=0 -> outputs return asynchronously to reset values.
  - After release, in_ready=1 and out_valid=0, with no spurious out_valid.
- Equivalence with the original 2-bit slice, WIDTH=2, op=0:
  - x=3, y=3, z=1 -> u=2'b01, u_hi=1'b1, w=2'b00, w_cout=1.
  - Out_valid exactly 2 cycles after accept.
  - Sweep all 32 combinations of x, y, z against the golden model.
- WIDTH=8 multiply:
  - x=0x53, y=0xCA, z=1 -> u=0x7E, u_hi=0x3F, w=0xCB, w_cout=0.
  - Latency 8, or 8 with EARLY_EXIT=1 since y[7]=1.
- Early exit and bypass:
  - EARLY_EXIT=1, x=0xFF, y=0x01 -> u=0xFF, u_hi=0, out_valid at T+1.
  - op=1, y=0xFF, z=1 -> w=0x00, w_cout=1, u=0, out_valid at T+1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> u, u_hi, w and w_cout are stable and in_ready=0.
  - Asserting in_valid with new operands during this period has no effect.
  - After out_ready=1, the next transaction is accepted exactly one cycle later.
- Randomised back-to-back:
  - 1000 transactions, random op, in_valid and out_ready, WIDTH=8 and 13 -> all results match the carry-less reference model.
  - No lost or duplicated transactions.

Source files
------------

// File: rtl/clmul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : clmul_seq
//  Description : Sequential carry-less (GF(2)) multiplier with a side
//                incrementer. Each transaction produces
//                  {u_hi, u}   = x * y  (polynomial product, 2*WIDTH-1 bits)
//                  {w_cout, w} = y + z  (ordinary integer add)
//                The product is built by shift-and-XOR, one multiplier bit
//                per clock, behind valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       operand width, 2..32
//    EARLY_EXIT  1 = stop as soon as the unprocessed multiplier bits are zero
//  Ports
//    clk         clock, rising edge
//    rst_n       asynchronous reset, active low
//    in_valid    operand set valid
//    in_ready    block can accept operands (IDLE only)
//    op          0 = multiply + increment, 1 = increment only
//    x           multiplicand
//    y           multiplier and addend
//    z           increment / carry-in
//    out_valid   results valid (DONE only)
//    out_ready   consumer accepts results
//    u           product bits [WIDTH-1:0]
//    u_hi        product bits [2*WIDTH-2:WIDTH]
//    w           (y + z) mod 2^WIDTH
//    w_cout      carry out of y + z
// ============================================================================
module clmul_seq #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] u,
    output logic [WIDTH-2:0] u_hi,
    output logic [WIDTH-1:0] w,
    output logic             w_cout
);

    // Accumulator spans the full product degree range 0..2*WIDTH-2.
    localparam int              c_ACC_W    = 2 * WIDTH - 1;
    localparam int              c_IDX_W    = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_ONE_IDX  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_IDX_W-1:0]   r_i;
    logic [WIDTH-1:0]     r_w;
    logic                 r_w_cout;

    logic [c_ACC_W-1:0]   w_x_in_ext;
    logic [c_ACC_W-1:0]   w_x_reg_ext;
    logic [c_ACC_W-1:0]   w_pp;
    logic                 w_in_rest_zero;
    logic                 w_run_rest_zero;
    logic                 w_run_last;
    logic [WIDTH:0]       w_sum;

    // ------------------------------------------------------------------------
    // Combinational datapath helpers
    // ------------------------------------------------------------------------
    assign w_x_in_ext  = {{(WIDTH-1){1'b0}}, x};
    assign w_x_reg_ext = {{(WIDTH-1){1'b0}}, r_x};

    // Partial product for the multiplier bit selected by r_i.
    assign w_pp = r_y[r_i] ? (w_x_reg_ext << r_i) : '0;

    // Bit 0 of the incoming multiplier is folded into the accept cycle, so
    // "rest zero" at accept means y[WIDTH-1:1] == 0.
    assign w_in_rest_zero  = ((y >> 1) == '0);

    // During RUN, r_i is the bit being processed now; the run may end when
    // no set bit remains above it, i.e. (r_y >> r_i) is 0 or 1.
    assign w_run_rest_zero = ((r_y >> r_i) <= WIDTH'(1));

    assign w_run_last = (r_i == c_LAST_IDX) ||
                        ((EARLY_EXIT != 0) && w_run_rest_zero);

    assign w_sum = {1'b0, y} + {{WIDTH{1'b0}}, z};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op) begin
                        w_state_nxt = S_DONE;
                    end else if ((EARLY_EXIT != 0) && w_in_rest_zero) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_run_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    //   The accept cycle already applies multiplier bit 0 (straight from the
    //   y input), so RUN only walks bits 1..WIDTH-1. This makes a full
    //   multiply take WIDTH cycles from accept to out_valid, and lets an
    //   early exit on y <= 1 finish as fast as the bypass path.
    //   op only steers the FSM at accept time, so it is not stored.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_i      <= '0;
            r_w      <= '0;
            r_w_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x                <= x;
                        r_y                <= y;
                        {r_w_cout, r_w}    <= w_sum;
                        if (op) begin
                            r_acc <= '0;
                            r_i   <= '0;
                        end else begin
                            r_acc <= y[0] ? w_x_in_ext : '0;
                            r_i   <= c_ONE_IDX;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc ^ w_pp;
                    r_i   <= r_i + c_ONE_IDX;
                end
                default: begin
                    // DONE: everything held so outputs are stable under
                    // backpressure.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign u      = r_acc[WIDTH-1:0];
    assign u_hi   = r_acc[c_ACC_W-1:WIDTH];
    assign w      = r_w;
    assign w_cout = r_w_cout;

endmodule
`default_nettype wire

// File: tb/tb_clmul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clmul_seq
//  Description : Self-checking bench for clmul_seq (WIDTH 2, 8, 8+early-exit,
//                13+early-exit instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clmul_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- WIDTH=2 ----------------
    logic       s2_in_valid, s2_in_ready, s2_op, s2_z, s2_out_valid, s2_out_ready, s2_w_cout;
    logic [1:0] s2_x, s2_y, s2_u, s2_w;
    logic [0:0] s2_u_hi;
    // ---------------- WIDTH=8 ----------------
    logic       s8_in_valid, s8_in_ready, s8_op, s8_z, s8_out_valid, s8_out_ready, s8_w_cout;
    logic [7:0] s8_x, s8_y, s8_u, s8_w;
    logic [6:0] s8_u_hi;
    // ---------------- WIDTH=8, EARLY_EXIT=1 ----------------
    logic       e8_in_valid, e8_in_ready, e8_op, e8_z, e8_out_valid, e8_out_ready, e8_w_cout;
    logic [7:0] e8_x, e8_y, e8_u, e8_w;
    logic [6:0] e8_u_hi;
    // ---------------- WIDTH=13, EARLY_EXIT=1 ----------------
    logic        s13_in_valid, s13_in_ready, s13_op, s13_z, s13_out_valid, s13_out_ready, s13_w_cout;
    logic [12:0] s13_x, s13_y, s13_u, s13_w;
    logic [11:0] s13_u_hi;

    clmul_seq #(.WIDTH(2), .EARLY_EXIT(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .op(s2_op), .x(s2_x), .y(s2_y), .z(s2_z), .out_valid(s2_out_valid),
        .out_ready(s2_out_ready), .u(s2_u), .u_hi(s2_u_hi), .w(s2_w), .w_cout(s2_w_cout));

    clmul_seq #(.WIDTH(8), .EARLY_EXIT(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .op(s8_op), .x(s8_x), .y(s8_y), .z(s8_z), .out_valid(s8_out_valid),
        .out_ready(s8_out_ready), .u(s8_u), .u_hi(s8_u_hi), .w(s8_w), .w_cout(s8_w_cout));

    clmul_seq #(.WIDTH(8), .EARLY_EXIT(1)) u_e8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e8_in_valid), .in_ready(e8_in_ready),
        .op(e8_op), .x(e8_x), .y(e8_y), .z(e8_z), .out_valid(e8_out_valid),
        .out_ready(e8_out_ready), .u(e8_u), .u_hi(e8_u_hi), .w(e8_w), .w_cout(e8_w_cout));

    clmul_seq #(.WIDTH(13), .EARLY_EXIT(1)) u_d13 (
        .clk(clk), .rst_n(rst_n), .in_valid(s13_in_valid), .in_ready(s13_in_ready),
        .op(s13_op), .x(s13_x), .y(s13_y), .z(s13_z), .out_valid(s13_out_valid),
        .out_ready(s13_out_ready), .u(s13_u), .u_hi(s13_u_hi), .w(s13_w), .w_cout(s13_w_cout));

    // Carry-less reference product of the low wd bits of a and b.
    function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b, input int wd);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < wd; i++) begin
            if (b[i]) r = r ^ ({32'd0, a} << i);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Single-transaction drivers: drive at a negedge, report outputs seen
    // when out_valid rises and the latency in cycles from the accept cycle.
    // ------------------------------------------------------------------------
    task automatic run2(input logic [1:0] tx, input logic [1:0] ty, input logic tz, input logic top,
                        output logic [2:0] prod, output logic [2:0] sum, output int lat);
        int t;
        @(negedge clk);
        s2_x = tx; s2_y = ty; s2_z = tz; s2_op = top; s2_in_valid = 1'b1; s2_out_ready = 1'b1;
        t = 0;
        while (!s2_in_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk); s2_in_valid = 1'b0; lat = 1;
        while (!s2_out_valid && lat < 100) begin @(negedge clk); lat++; end
        prod = {s2_u_hi, s2_u}; sum = {s2_w_cout, s2_w};
        @(negedge clk);
    endtask

    task automatic run8(input logic [7:0] tx, input logic [7:0] ty, input logic tz, input logic top,
                        output logic [14:0] prod, output logic [8:0] sum, output int lat);
        int t;
        @(negedge clk);
        s8_x = tx; s8_y = ty; s8_z = tz; s8_op = top; s8_in_valid = 1'b1; s8_out_ready = 1'b1;
        t = 0;
        while (!s8_in_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk); s8_in_valid = 1'b0; lat = 1;
        while (!s8_out_valid && lat < 100) begin @(negedge clk); lat++; end
        prod = {s8_u_hi, s8_u}; sum = {s8_w_cout, s8_w};
        @(negedge clk);
    endtask

    task automatic rune8(input logic [7:0] tx, input logic [7:0] ty, input logic tz, input logic top,
                         output logic [14:0] prod, output logic [8:0] sum, output int lat);
        int t;
        @(negedge clk);
        e8_x = tx; e8_y = ty; e8_z = tz; e8_op = top; e8_in_valid = 1'b1; e8_out_ready = 1'b1;
        t = 0;
        while (!e8_in_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk); e8_in_valid = 1'b0; lat = 1;
        while (!e8_out_valid && lat < 100) begin @(negedge clk); lat++; end
        prod = {e8_u_hi, e8_u}; sum = {e8_w_cout, e8_w};
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s8_in_ready, s8_out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_hs: in_ready,out_valid=%b expected 10", {s8_in_ready, s8_out_valid});
        end
        n_tests++;
        if ({s8_u_hi, s8_u, s8_w_cout, s8_w} !== 24'd0) begin
            n_fail++; $display("FAIL reset_data: u_hi,u,w_cout,w=%h expected 0", {s8_u_hi, s8_u, s8_w_cout, s8_w});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        bit seen;
        int t;
        @(negedge clk);
        s8_x = 8'hFF; s8_y = 8'hFF; s8_z = 1'b0; s8_op = 1'b0; s8_in_valid = 1'b1; s8_out_ready = 1'b1;
        t = 0;
        while (!s8_in_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk); s8_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s8_out_valid, s8_w} !== 9'h0FF) begin
            n_fail++; $display("FAIL midrun_pre: out_valid,w=%h expected 0ff", {s8_out_valid, s8_w});
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({s8_in_ready, s8_out_valid, s8_u_hi, s8_u, s8_w_cout, s8_w} !== {2'b10, 24'd0}) begin
            n_fail++; $display("FAIL midrun_async: rdy,vld,u_hi,u,w_cout,w=%h expected %h",
                               {s8_in_ready, s8_out_valid, s8_u_hi, s8_u, s8_w_cout, s8_w}, {2'b10, 24'd0});
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (s8_out_valid || !s8_in_ready) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL midrun_after: spurious out_valid or in_ready low = %b expected 0", seen);
        end
    endtask

    task automatic test_slice2();
        logic [2:0] p, s, es;
        logic [63:0] r;
        int l;
        run2(2'd3, 2'd3, 1'b1, 1'b0, p, s, l);
        n_tests++;
        if (p !== 3'b101 || s !== 3'b100 || l != 2) begin
            n_fail++; $display("FAIL slice2_33: prod=%b sum=%b lat=%0d expected 101 100 2", p, s, l);
        end
        for (int xi = 0; xi < 4; xi++) begin
            for (int yi = 0; yi < 4; yi++) begin
                for (int zi = 0; zi < 2; zi++) begin
                    run2(2'(xi), 2'(yi), 1'(zi), 1'b0, p, s, l);
                    r  = clmul_ref(32'(xi), 32'(yi), 2);
                    es = 3'(yi + zi);
                    n_tests++;
                    if (p !== r[2:0] || s !== es || l != 2) begin
                        n_fail++; $display("FAIL slice2_sweep x=%0d y=%0d z=%0d: prod=%b sum=%b lat=%0d expected %b %b 2",
                                           xi, yi, zi, p, s, l, r[2:0], es);
                    end
                end
            end
        end
    endtask

    task automatic test_mul8();
        logic [14:0] p;
        logic [8:0]  s;
        int l;
        run8(8'h53, 8'hCA, 1'b1, 1'b0, p, s, l);
        n_tests++;
        if (p !== {7'h3F, 8'h7E} || s !== 9'h0CB || l != 8) begin
            n_fail++; $display("FAIL mul8: prod=%h sum=%h lat=%0d expected 3f7e 0cb 8", p, s, l);
        end
        rune8(8'h53, 8'hCA, 1'b1, 1'b0, p, s, l);
        n_tests++;
        if (p !== {7'h3F, 8'h7E} || s !== 9'h0CB || l != 8) begin
            n_fail++; $display("FAIL mul8_ee: prod=%h sum=%h lat=%0d expected 3f7e 0cb 8", p, s, l);
        end
    endtask

    task automatic test_early_exit();
        logic [14:0] p;
        logic [8:0]  s;
        int l;
        rune8(8'hFF, 8'h01, 1'b0, 1'b0, p, s, l);
        n_tests++;
        if (p !== 15'h00FF || s !== 9'h001 || l != 1) begin
            n_fail++; $display("FAIL ee_y1: prod=%h sum=%h lat=%0d expected 00ff 001 1", p, s, l);
        end
        rune8(8'hA5, 8'h00, 1'b1, 1'b0, p, s, l);
        n_tests++;
        if (p !== 15'h0000 || s !== 9'h001 || l != 1) begin
            n_fail++; $display("FAIL ee_y0: prod=%h sum=%h lat=%0d expected 0000 001 1", p, s, l);
        end
        rune8(8'h53, 8'h06, 1'b0, 1'b0, p, s, l);
        n_tests++;
        if (p !== 15'h01EA || s !== 9'h006 || l != 3) begin
            n_fail++; $display("FAIL ee_y6: prod=%h sum=%h lat=%0d expected 01ea 006 3", p, s, l);
        end
    endtask

    task automatic test_bypass();
        logic [14:0] p;
        logic [8:0]  s;
        int l;
        run8(8'h5A, 8'hFF, 1'b1, 1'b1, p, s, l);
        n_tests++;
        if (p !== 15'h0000 || s !== 9'h100 || l != 1) begin
            n_fail++; $display("FAIL bypass: prod=%h sum=%h lat=%0d expected 0000 100 1", p, s, l);
        end
    endtask

    task automatic test_backpressure();
        int t;
        @(negedge clk);
        s8_x = 8'h53; s8_y = 8'hCA; s8_z = 1'b1; s8_op = 1'b0; s8_in_valid = 1'b1; s8_out_ready = 1'b0;
        t = 0;
        while (!s8_in_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk); s8_in_valid = 1'b0;
        t = 0;
        while (!s8_out_valid && t < 100) begin @(negedge clk); t++; end
        // New operands offered while results are stalled must be ignored.
        s8_x = 8'h11; s8_y = 8'h22; s8_z = 1'b0; s8_op = 1'b1; s8_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({s8_in_ready, s8_out_valid, s8_u_hi, s8_u, s8_w_cout, s8_w} !== {2'b01, 7'h3F, 8'h7E, 9'h0CB}) begin
                n_fail++; $display("FAIL bp_hold cyc%0d: rdy,vld,u_hi,u,w_cout,w=%h expected %h", c,
                                   {s8_in_ready, s8_out_valid, s8_u_hi, s8_u, s8_w_cout, s8_w},
                                   {2'b01, 7'h3F, 8'h7E, 9'h0CB});
            end
            @(negedge clk);
        end
        s8_out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({s8_in_ready, s8_out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bp_release: in_ready,out_valid=%b expected 10", {s8_in_ready, s8_out_valid});
        end
        @(negedge clk);
        s8_in_valid = 1'b0;
        n_tests++;
        if ({s8_out_valid, s8_u_hi, s8_u, s8_w_cout, s8_w} !== {1'b1, 15'd0, 9'h022}) begin
            n_fail++; $display("FAIL bp_next: vld,u_hi,u,w_cout,w=%h expected %h",
                               {s8_out_valid, s8_u_hi, s8_u, s8_w_cout, s8_w}, {1'b1, 15'd0, 9'h022});
        end
        @(negedge clk);
    endtask

    task automatic test_random8(input int n);
        logic [14:0] q_prod[$];
        logic [8:0]  q_sum[$];
        logic [14:0] ep;
        logic [8:0]  es;
        logic [63:0] r;
        int acc_n = 0, got = 0, cyc = 0;
        while (got < n && cyc < 40 * n) begin
            @(negedge clk); cyc++;
            s8_in_valid  = (acc_n < n) && ($urandom_range(0, 3) != 0);
            s8_x         = 8'($urandom);
            s8_y         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            s8_z         = 1'($urandom);
            s8_op        = ($urandom_range(0, 3) == 0);
            s8_out_ready = ($urandom_range(0, 3) != 0);
            if (s8_out_valid && s8_out_ready) begin
                n_tests++; got++;
                if (q_prod.size() == 0) begin
                    n_fail++; $display("FAIL rand8_extra: output with empty scoreboard u=%h", s8_u);
                end else begin
                    ep = q_prod.pop_front(); es = q_sum.pop_front();
                    if ({s8_u_hi, s8_u} !== ep || {s8_w_cout, s8_w} !== es) begin
                        n_fail++; $display("FAIL rand8 #%0d: prod=%h sum=%h expected %h %h",
                                           got, {s8_u_hi, s8_u}, {s8_w_cout, s8_w}, ep, es);
                    end
                end
            end
            if (s8_in_valid && s8_in_ready) begin
                r = clmul_ref(32'(s8_x), 32'(s8_y), 8);
                q_prod.push_back(s8_op ? 15'd0 : r[14:0]);
                q_sum.push_back({1'b0, s8_y} + 9'(s8_z));
                acc_n++;
            end
        end
        s8_in_valid = 1'b0; s8_out_ready = 1'b1;
        n_tests++;
        if (got != n || acc_n != n || q_prod.size() != 0) begin
            n_fail++; $display("FAIL rand8_count: accepted=%0d received=%0d left=%0d expected %0d %0d 0",
                               acc_n, got, q_prod.size(), n, n);
        end
    endtask

    task automatic test_random13(input int n);
        logic [24:0] q_prod[$];
        logic [13:0] q_sum[$];
        logic [24:0] ep;
        logic [13:0] es;
        logic [63:0] r;
        int acc_n = 0, got = 0, cyc = 0;
        while (got < n && cyc < 40 * n) begin
            @(negedge clk); cyc++;
            s13_in_valid  = (acc_n < n) && ($urandom_range(0, 3) != 0);
            s13_x         = 13'($urandom);
            s13_y         = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom);
            s13_z         = 1'($urandom);
            s13_op        = ($urandom_range(0, 3) == 0);
            s13_out_ready = ($urandom_range(0, 3) != 0);
            if (s13_out_valid && s13_out_ready) begin
                n_tests++; got++;
                if (q_prod.size() == 0) begin
                    n_fail++; $display("FAIL rand13_extra: output with empty scoreboard u=%h", s13_u);
                end else begin
                    ep = q_prod.pop_front(); es = q_sum.pop_front();
                    if ({s13_u_hi, s13_u} !== ep || {s13_w_cout, s13_w} !== es) begin
                        n_fail++; $display("FAIL rand13 #%0d: prod=%h sum=%h expected %h %h",
                                           got, {s13_u_hi, s13_u}, {s13_w_cout, s13_w}, ep, es);
                    end
                end
            end
            if (s13_in_valid && s13_in_ready) begin
                r = clmul_ref(32'(s13_x), 32'(s13_y), 13);
                q_prod.push_back(s13_op ? 25'd0 : r[24:0]);
                q_sum.push_back({1'b0, s13_y} + 14'(s13_z));
                acc_n++;
            end
        end
        s13_in_valid = 1'b0; s13_out_ready = 1'b1;
        n_tests++;
        if (got != n || acc_n != n || q_prod.size() != 0) begin
            n_fail++; $display("FAIL rand13_count: accepted=%0d received=%0d left=%0d expected %0d %0d 0",
                               acc_n, got, q_prod.size(), n, n);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        s2_in_valid = 0;  s2_op = 0;  s2_x = '0;  s2_y = '0;  s2_z = 0;  s2_out_ready = 1;
        s8_in_valid = 0;  s8_op = 0;  s8_x = '0;  s8_y = '0;  s8_z = 0;  s8_out_ready = 1;
        e8_in_valid = 0;  e8_op = 0;  e8_x = '0;  e8_y = '0;  e8_z = 0;  e8_out_ready = 1;
        s13_in_valid = 0; s13_op = 0; s13_x = '0; s13_y = '0; s13_z = 0; s13_out_ready = 1;
        rst_n = 1'b0;

        test_reset();
        test_reset_midrun();
        test_slice2();
        test_mul8();
        test_early_exit();
        test_bypass();
        test_backpressure();
        test_random8(1000);
        test_random13(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
